// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int BEAT_W        = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for an n-entry requester vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = idx_w(NREQ_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of (req & ~excl) at or above start, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0]   masked;
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW:0]    offset;
  logic [IW:0]    sum;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    masked  = req_i & ~excl_i;
    doubled = {masked, masked};
    rotated = doubled[{1'b0, start_i} +: N];
    found_o = 1'b0;
    offset  = '0;
    // Descending scan so the smallest offset from start_i wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found_o = 1'b1;
        offset  = (IW+1)'(k);
      end
    end
    sum     = {1'b0, start_i} + offset;
    index_o = (sum >= N_W) ? IW'(sum - N_W) : IW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers with bounded bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic [DW-1:0]            fifo_din,
  output logic                     fifo_wr_en,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IW-1:0]     LAST_ID   = IW'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [DW-1:0]     data_arr [NREQ];
  logic              owner_valid, xfer, release_now, pick_found;
  logic [IW-1:0]     grant_inc, pick_start, pick_idx;
  logic [NREQ-1:0]   pick_excl;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  always_comb begin
    owner_valid = req_valid[grant_q];
    grant_inc   = (grant_q == LAST_ID) ? '0 : grant_q + IW'(1);
    xfer        = (state_q == GRANT) && owner_valid && !fifo_full;
    release_now = (state_q == GRANT) &&
                  (!owner_valid || (xfer && (beat_q == LAST_BEAT)));
    // One picker serves both IDLE and release: in GRANT it scans from the rotated pointer.
    pick_start  = (state_q == GRANT) ? grant_inc : rr_ptr_q;
    pick_excl   = '0;
    if ((state_q == GRANT) && !owner_valid) pick_excl[grant_q] = 1'b1;
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          rr_ptr_d = grant_inc;
          beat_d   = '0;
          if (pick_found) grant_d = pick_idx;
          else            state_d = IDLE;
        end else if (xfer) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == GRANT);
    grant_id   = grant_q;
    fifo_wr_en = xfer && !reset;
    req_ready  = '0;
    if (fifo_wr_en) req_ready[grant_q] = 1'b1;
    fifo_din   = busy ? data_arr[grant_q] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: producer models feed fifo_wr_arbiter; observed writes are compared to hand-derived logs.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic [DW-1:0]     fifo_din;
  logic              fifo_wr_en;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Producer and test-control state
  int          rem [NREQ];
  logic [15:0] nxt [NREQ];
  int          cyc;
  int          full_from, full_to, rst_at;
  int          viol_full, viol_rst, viol_ready;

  // Observed and expected write logs
  int          log_gid [$];
  logic [15:0] log_din [$];
  int          log_cyc [$];
  int          exp_gid [$];
  logic [15:0] exp_din [$];
  int          exp_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = (rem[i] > 0);
      req_data[i*DW +: DW]   = nxt[i];
    end
    fifo_full = (cyc >= full_from) && (cyc < full_to);
    reset     = (cyc == rst_at);
  endtask

  task automatic run_until(input int target);
    logic [NREQ-1:0] rdy;
    while (cyc < target) begin
      @(negedge clk);
      rdy = req_ready;
      if (fifo_wr_en) begin
        log_gid.push_back(int'(grant_id));
        log_din.push_back(fifo_din);
        log_cyc.push_back(cyc);
      end
      if (fifo_wr_en && fifo_full) viol_full++;
      if (reset && (fifo_wr_en || (req_ready != '0))) viol_rst++;
      if (($countones(req_ready) > 1) || (fifo_wr_en != (|req_ready))) viol_ready++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) begin
          rem[i]--;
          nxt[i]++;
        end
      end
      cyc++;
      apply_inputs();
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '1;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en_forced", fifo_wr_en, 0);
    check("rst_ready_forced", req_ready, 0);
    reset     = 1'b0;
    req_valid = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_din", fifo_din, 0);
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      nxt[i] = 16'h1000 * 16'(i + 1);
    end
    full_from = -1;
    full_to   = -1;
    rst_at    = -1;
  endtask

  task automatic launch();
    cyc = 0;
    viol_full = 0;
    viol_rst  = 0;
    viol_ready = 0;
    log_gid.delete(); log_din.delete(); log_cyc.delete();
    exp_gid.delete(); exp_din.delete(); exp_cyc.delete();
    apply_inputs();
  endtask

  task automatic expect_wr(input int g, input logic [15:0] d, input int c);
    exp_gid.push_back(g);
    exp_din.push_back(d);
    exp_cyc.push_back(c);
  endtask

  task automatic check_log(input string tag);
    check({tag, ".n_writes"}, log_gid.size(), exp_gid.size());
    for (int i = 0; i < exp_gid.size() && i < log_gid.size(); i++) begin
      check($sformatf("%s[%0d].gid", tag, i), log_gid[i], exp_gid[i]);
      check($sformatf("%s[%0d].din", tag, i), log_din[i], exp_din[i]);
      check($sformatf("%s[%0d].cyc", tag, i), log_cyc[i], exp_cyc[i]);
    end
    check({tag, ".wr_while_full"}, viol_full, 0);
    check({tag, ".out_in_reset"}, viol_rst, 0);
    check({tag, ".ready_onehot"}, viol_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single requester: three beats 0x55..0x57, first write the cycle after valid.
    do_reset();
    rem[0] = 3;
    nxt[0] = 16'h0055;
    launch();
    #1;
    check("t1.idle_no_write", fifo_wr_en, 0);
    run_until(6);
    expect_wr(0, 16'h0055, 1);
    expect_wr(0, 16'h0056, 2);
    expect_wr(0, 16'h0057, 3);
    check_log("t1");
    check("t1.busy_after", busy, 0);

    // All four continuously valid: 0,1,2,3,0,1,2,3 bursts of 4, no gaps.
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 8;
    launch();
    run_until(36);
    for (int n = 0; n < 32; n++) begin
      int g;
      g = (n / 4) % 4;
      expect_wr(g, 16'h1000 * 16'(g + 1) + 16'((n / 16) * 4 + n % 4), n + 1);
    end
    check_log("t2");

    // FIFO full for 3 cycles after two beats: stall holds the burst count.
    do_reset();
    rem[0] = 6;
    rem[1] = 4;
    full_from = 3;
    full_to   = 6;
    launch();
    run_until(3);
    #1;
    check("t3.stall_wr_en", fifo_wr_en, 0);
    check("t3.stall_ready", req_ready, 0);
    check("t3.stall_busy", busy, 1);
    check("t3.stall_din", fifo_din, 16'h1002);
    run_until(16);
    expect_wr(0, 16'h1000, 1);
    expect_wr(0, 16'h1001, 2);
    expect_wr(0, 16'h1002, 6);
    expect_wr(0, 16'h1003, 7);
    for (int n = 0; n < 4; n++) expect_wr(1, 16'h2000 + 16'(n), 8 + n);
    expect_wr(0, 16'h1004, 12);
    expect_wr(0, 16'h1005, 13);
    check_log("t3");

    // req1 drops after 2 beats with req2 pending: release cycle is write-free, then req2.
    do_reset();
    rem[1] = 2;
    rem[2] = 3;
    launch();
    run_until(3);
    #1;
    check("t4.release_wr_en", fifo_wr_en, 0);
    check("t4.release_gid", grant_id, 1);
    run_until(4);
    #1;
    check("t4.handover_gid", grant_id, 2);
    check("t4.handover_wr_en", fifo_wr_en, 1);
    run_until(10);
    expect_wr(1, 16'h2000, 1);
    expect_wr(1, 16'h2001, 2);
    expect_wr(2, 16'h3000, 4);
    expect_wr(2, 16'h3001, 5);
    expect_wr(2, 16'h3002, 6);
    check_log("t4");

    // Reset for one cycle mid-burst on req3; afterwards lowest valid index wins.
    do_reset();
    rem[3] = 8;
    rst_at = 3;
    launch();
    run_until(3);
    #1;
    check("t5.rst_wr_en", fifo_wr_en, 0);
    check("t5.rst_ready", req_ready, 0);
    run_until(4);
    rem[1] = 2;
    apply_inputs();
    #1;
    check("t5.post_rst_busy", busy, 0);
    check("t5.post_rst_din", fifo_din, 0);
    check("t5.post_rst_wr_en", fifo_wr_en, 0);
    run_until(17);
    expect_wr(3, 16'h4000, 1);
    expect_wr(3, 16'h4001, 2);
    expect_wr(1, 16'h2000, 5);
    expect_wr(1, 16'h2001, 6);
    for (int n = 0; n < 6; n++) expect_wr(3, 16'h4002 + 16'(n), 8 + n);
    check_log("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
